// File: rtl/dnn_ctrl_pkg.sv
// dnn_ctrl_pkg: shared types and constants for the inference run sequencer
package dnn_ctrl_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int IDX_WIDTH   = 4;
    localparam int NUM_CLASSES = 10;
    localparam logic [IDX_WIDTH-1:0] ERR_DIGIT = 4'hF;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_WAIT,
        S_SCAN,
        S_RESULT
    } ctrl_state_t;
endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker: running signed max/arg over scanned class scores, lowest index wins ties
module argmax_tracker
    import dnn_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [IDX_WIDTH-1:0]  idx_i,
    input  logic [DATA_WIDTH-1:0] score_i,
    output logic [DATA_WIDTH-1:0] nxt_max_o,
    output logic [IDX_WIDTH-1:0]  nxt_arg_o
);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic [DATA_WIDTH-1:0] max_q;
    logic [IDX_WIDTH-1:0]  arg_q;
    logic                  take;
    // Strict greater-than keeps the earlier index when scores tie
    always_comb begin
        take      = en_i && ($signed(score_i) > $signed(max_q));
        nxt_max_o = take ? score_i : max_q;
        nxt_arg_o = take ? idx_i : arg_q;
    end
    // Running best, restarted from the most-negative score at the start of each scan
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            max_q <= MOST_NEG;
            arg_q <= '0;
        end else if (clr_i) begin
            max_q <= MOST_NEG;
            arg_q <= '0;
        end else begin
            max_q <= nxt_max_o;
            arg_q <= nxt_arg_o;
        end
    end
endmodule

// File: rtl/dnn_infer_ctrl.sv
// dnn_infer_ctrl: sequences one engine run per request and returns the argmax class
module dnn_infer_ctrl
    import dnn_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int TO_WIDTH       = 21
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  busy_o,
    output logic                  eng_reset_o,
    output logic                  eng_start_o,
    input  logic                  eng_done_i,
    output logic [IDX_WIDTH-1:0]  out_idx_o,
    input  logic [DATA_WIDTH-1:0] eng_out_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [IDX_WIDTH-1:0]  res_digit_o,
    output logic [DATA_WIDTH-1:0] res_score_o,
    output logic                  res_err_o
);
    ctrl_state_t           state_q, state_d;
    logic [TO_WIDTH-1:0]   wd_q, wd_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [IDX_WIDTH-1:0]  digit_q, digit_d;
    logic [DATA_WIDTH-1:0] score_q, score_d;
    logic                  err_q, err_d;
    logic                  trk_clr, trk_en;
    logic [DATA_WIDTH-1:0] nxt_max;
    logic [IDX_WIDTH-1:0]  nxt_arg;

    argmax_tracker u_trk (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (trk_clr),
        .en_i      (trk_en),
        .idx_i     (idx_q),
        .score_i   (eng_out_i),
        .nxt_max_o (nxt_max),
        .nxt_arg_o (nxt_arg)
    );

    // Next-state, watchdog, scan index and result capture
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        score_d = score_q;
        err_d   = err_q;
        trk_clr = 1'b0;
        trk_en  = 1'b0;
        case (state_q)
            S_IDLE: state_d = req_i ? S_CLR : S_IDLE;
            S_CLR: begin
                state_d = S_START;
                digit_d = '0;
                score_d = '0;
                err_d   = 1'b0;
            end
            S_START: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end
            S_WAIT: begin
                if (eng_done_i) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                    trk_clr = 1'b1;
                end else if (wd_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_RESULT;
                    err_d   = 1'b1;
                    digit_d = ERR_DIGIT;
                    score_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_SCAN: begin
                trk_en = 1'b1;
                if (idx_q == IDX_WIDTH'(NUM_CLASSES - 1)) begin
                    state_d = S_RESULT;
                    idx_d   = '0;
                    digit_d = nxt_arg;
                    score_d = nxt_max;
                    err_d   = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_RESULT: state_d = res_ready_i ? S_IDLE : S_RESULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            wd_q    <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            score_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            score_q <= score_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = state_q != S_IDLE;
    assign eng_reset_o = state_q == S_CLR;
    assign eng_start_o = state_q == S_START;
    assign res_valid_o = state_q == S_RESULT;
    assign out_idx_o   = idx_q;
    assign res_digit_o = digit_q;
    assign res_score_o = score_q;
    assign res_err_o   = err_q;
endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// tb_dnn_infer_ctrl: randomized run-sequencer bench against an argmax reference model
module tb_dnn_infer_ctrl;
    localparam int TO = 64;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        busy, eng_reset, eng_start;
    logic        eng_done = 1'b0;
    logic [3:0]  out_idx;
    logic [15:0] eng_out;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [3:0]  res_digit;
    logic [15:0] res_score;
    logic        res_err;
    logic [15:0] sc [10];
    int          n_tests = 0;
    int          n_fail = 0;

    dnn_infer_ctrl #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(21)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .busy_o      (busy),
        .eng_reset_o (eng_reset),
        .eng_start_o (eng_start),
        .eng_done_i  (eng_done),
        .out_idx_o   (out_idx),
        .eng_out_i   (eng_out),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_digit_o (res_digit),
        .res_score_o (res_score),
        .res_err_o   (res_err)
    );

    always #5 clk = ~clk;

    // Engine output mux model
    always_comb eng_out = (out_idx < 4'd10) ? sc[out_idx] : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // First index holding the largest signed score
    function automatic int ref_arg();
        int b = 0;
        for (int i = 1; i < 10; i++)
            if ($signed(sc[i]) > $signed(sc[b])) b = i;
        return b;
    endfunction

    task automatic run(input int dly, input bit nodone, input int hold);
        int w;
        logic [3:0]  e_dig;
        logic [15:0] e_sc;
        int exp_idx;
        e_dig = nodone ? 4'hF : 4'(ref_arg());
        e_sc  = nodone ? 16'h0 : sc[ref_arg()];
        eng_done = 1'b0;
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("clr_pulse", {busy, eng_reset, eng_start}, 3'b110);
        @(negedge clk);
        check("start_pulse", {busy, eng_reset, eng_start}, 3'b101);
        @(negedge clk);
        w = 0;
        while (!res_valid && w < 400) begin
            exp_idx = (!nodone && w > dly && w <= dly + 10) ? w - dly - 1 : 0;
            check("out_idx", {eng_reset, eng_start, out_idx}, {2'b00, 4'(exp_idx)});
            eng_done = !nodone && (w >= dly);
            req = 1'($urandom_range(0, 1));
            @(negedge clk);
            w++;
        end
        check("valid_lat", w, nodone ? TO : dly + 11);
        eng_done = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            check("result", {res_valid, busy, res_err, res_digit, res_score},
                  {2'b11, nodone, e_dig, e_sc});
            if (h < hold) begin
                req = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        req = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("idle", {res_valid, busy, out_idx, res_digit, res_score}, {2'b00, 4'h0, e_dig, e_sc});
    endtask

    task automatic rnd_scores();
        for (int i = 0; i < 10; i++) sc[i] = 16'($urandom);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 10; i++) sc[i] = 16'h0;
        #1;
        check("rst_vals", {busy, eng_reset, eng_start, res_valid, res_err, out_idx, res_digit, res_score},
              {5'b0, 4'h0, 4'h0, 16'h0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sc = '{16'h0100, 16'h0200, 16'h7000, 16'h0050, 16'h1234, 16'h0000, 16'h6FFF, 16'h8000, 16'h0001, 16'h7000};
        run(39, 1'b0, 0);
        for (int i = 0; i < 10; i++) sc[i] = 16'h8000 + 16'($urandom_range(0, 16'h7E00));
        sc[3] = 16'hFF00;
        sc[7] = 16'hFF00;
        run($urandom_range(0, 20), 1'b0, 2);
        run(0, 1'b1, 1);
        rnd_scores();
        run(TO - 1, 1'b0, 0);
        rnd_scores();
        run(5, 1'b0, 20);
        rnd_scores();
        sc[9] = 16'h7FFF;
        run(3, 1'b0, 0);
        rnd_scores();
        sc[0] = 16'h7FFF;
        run(0, 1'b0, 0);
        for (int r = 0; r < 8; r++) begin
            rnd_scores();
            if (r[0]) sc[$urandom_range(0, 9)] = sc[$urandom_range(0, 9)];
            run($urandom_range(0, 30), 1'b0, $urandom_range(0, 3));
        end
        rnd_scores();
        @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        eng_done = 1'b1;
        w = 0;
        while (out_idx != 4'd5 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("reach_cls5", {busy, out_idx}, {1'b1, 4'd5});
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {busy, eng_reset, eng_start, res_valid, res_err, out_idx, res_digit, res_score},
              {5'b0, 4'h0, 4'h0, 16'h0});
        eng_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rnd_scores();
        run(7, 1'b0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
